// File: rtl/axi_sram_tester_pkg.sv
// Shared definitions for the AXI4-Lite SRAM tester: response codes, default
// widths and FSM state encodings.
package axi_sram_tester_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEF_ADDR_W = 18;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_FIN   = 3'd5
    } state_t;

endpackage

// File: rtl/axi_sram_tester.sv
// AXI4-Lite initiator: writes (addr[15:0] ^ seed) to len words from base, reads
// them back and reports mismatches / error responses, with a per-handshake timeout.
module axi_sram_tester
    import axi_sram_tester_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  logic                  a_clk,
    input  logic                  a_rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base,
    input  logic [ADDR_W-1:0]     len,
    input  logic [DATA_W-1:0]     seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic                  aw_valid,
    output logic [ADDR_W-1:0]     aw_addr,
    output logic                  aw_prot,
    input  logic                  aw_ready,
    output logic                  w_valid,
    output logic [DATA_W-1:0]     w_data,
    output logic [DATA_W/8-1:0]   w_strb,
    input  logic                  w_ready,
    output logic                  b_ready,
    input  logic                  b_valid,
    input  logic [1:0]            b_resp,
    output logic                  ar_valid,
    output logic [ADDR_W-1:0]     ar_addr,
    output logic                  ar_prot,
    input  logic                  ar_ready,
    output logic                  r_ready,
    input  logic                  r_valid,
    input  logic [DATA_W-1:0]     r_data,
    input  logic [1:0]            r_resp
);

    localparam int             TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

    state_t              r_state, w_state_nxt;
    logic [TW-1:0]       r_tcnt;
    logic [ADDR_W-1:0]   r_idx, r_base, r_len;
    logic [DATA_W-1:0]   r_seed;
    logic                r_busy, r_done, r_pass, r_timeout;
    logic [15:0]         r_err_count;
    logic [ADDR_W-1:0]   r_first_err_addr;
    logic                r_aw_valid, r_w_valid, r_b_ready, r_ar_valid, r_r_ready;
    logic                r_aw_done, r_w_done;
    logic [ADDR_W-1:0]   r_aw_addr, r_ar_addr;
    logic [DATA_W-1:0]   r_w_data;

    logic                w_start, w_abort, w_waiting, w_tmo_hit, w_last, w_err_ev;
    logic                w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [ADDR_W-1:0]   w_idx_inc, w_next_addr;

    assign w_start     = (r_state == S_IDLE) && start && !r_done;
    assign w_aw_hs     = r_aw_valid && aw_ready;
    assign w_w_hs      = r_w_valid && w_ready;
    assign w_b_hs      = r_b_ready && b_valid;
    assign w_ar_hs     = r_ar_valid && ar_ready;
    assign w_r_hs      = r_r_ready && r_valid;
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_next_addr = r_base + w_idx_inc;
    assign w_last      = (w_idx_inc == r_len);
    assign w_tmo_hit   = (r_tcnt == TMO_LAST);
    assign w_waiting   = (r_state == S_WADDR) || (r_state == S_WRESP) ||
                         (r_state == S_RADDR) || (r_state == S_RDATA);
    assign w_err_ev    = (w_b_hs && (b_resp != RESP_OKAY)) ||
                         (w_r_hs && ((r_resp != RESP_OKAY) ||
                                     (r_data != (DATA_W'(r_ar_addr[15:0]) ^ r_seed))));

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = (len != '0) ? S_WADDR : S_FIN;
            S_WADDR: if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) w_state_nxt = S_WRESP;
                     else if (w_tmo_hit) w_abort = 1'b1;
            S_WRESP: if (w_b_hs) w_state_nxt = w_last ? S_RADDR : S_WADDR;
                     else if (w_tmo_hit) w_abort = 1'b1;
            S_RADDR: if (w_ar_hs) w_state_nxt = S_RDATA;
                     else if (w_tmo_hit) w_abort = 1'b1;
            S_RDATA: if (w_r_hs) w_state_nxt = w_last ? S_FIN : S_RADDR;
                     else if (w_tmo_hit) w_abort = 1'b1;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_abort) w_state_nxt = S_FIN;
    end

    always_ff @(posedge a_clk) begin
        if (!a_rst) begin
            r_state <= S_IDLE;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || !w_waiting) r_tcnt <= '0;
            else                                         r_tcnt <= r_tcnt + 1'b1;
        end
    end

    always_ff @(posedge a_clk) begin
        if (!a_rst) begin
            r_idx <= '0; r_base <= '0; r_len <= '0; r_seed <= '0;
            r_busy <= 1'b0; r_done <= 1'b0; r_pass <= 1'b0; r_timeout <= 1'b0;
            r_err_count <= '0; r_first_err_addr <= '0;
            r_aw_valid <= 1'b0; r_w_valid <= 1'b0; r_b_ready <= 1'b0;
            r_ar_valid <= 1'b0; r_r_ready <= 1'b0;
            r_aw_done <= 1'b0; r_w_done <= 1'b0;
            r_aw_addr <= '0; r_ar_addr <= '0; r_w_data <= '0;
        end else begin
            // done trails FIN by one edge so a start coinciding with it is ignored
            r_done <= (r_state == S_FIN);
            r_busy <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
            if (r_state == S_FIN) r_pass <= (r_err_count == '0) && !r_timeout;

            case (r_state)
                S_IDLE: if (w_start) begin
                    r_base <= base; r_len <= len; r_seed <= seed; r_idx <= '0;
                    r_pass <= 1'b0; r_timeout <= 1'b0;
                    r_err_count <= '0; r_first_err_addr <= '0;
                    if (len != '0) begin
                        r_aw_valid <= 1'b1; r_w_valid <= 1'b1;
                        r_aw_done  <= 1'b0; r_w_done  <= 1'b0;
                        r_aw_addr  <= base;
                        r_w_data   <= DATA_W'(base[15:0]) ^ seed;
                    end
                end
                S_WADDR: begin
                    if (w_aw_hs) begin r_aw_valid <= 1'b0; r_aw_done <= 1'b1; end
                    if (w_w_hs)  begin r_w_valid  <= 1'b0; r_w_done  <= 1'b1; end
                    if (w_state_nxt == S_WRESP) r_b_ready <= 1'b1;
                end
                S_WRESP: if (w_b_hs) begin
                    r_b_ready <= 1'b0;
                    if (w_last) begin
                        r_idx <= '0; r_ar_valid <= 1'b1; r_ar_addr <= r_base;
                    end else begin
                        r_idx <= w_idx_inc;
                        r_aw_valid <= 1'b1; r_w_valid <= 1'b1;
                        r_aw_done  <= 1'b0; r_w_done  <= 1'b0;
                        r_aw_addr  <= w_next_addr;
                        r_w_data   <= DATA_W'(w_next_addr[15:0]) ^ r_seed;
                    end
                end
                S_RADDR: if (w_ar_hs) begin r_ar_valid <= 1'b0; r_r_ready <= 1'b1; end
                S_RDATA: if (w_r_hs) begin
                    r_r_ready <= 1'b0;
                    if (!w_last) begin
                        r_idx <= w_idx_inc; r_ar_valid <= 1'b1; r_ar_addr <= w_next_addr;
                    end
                end
                default: ;
            endcase

            if (w_err_ev) begin
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                if (r_err_count == '0)
                    r_first_err_addr <= (r_state == S_WRESP) ? r_aw_addr : r_ar_addr;
            end
            if (w_abort) begin
                r_aw_valid <= 1'b0; r_w_valid <= 1'b0; r_b_ready <= 1'b0;
                r_ar_valid <= 1'b0; r_r_ready <= 1'b0; r_timeout <= 1'b1;
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign timeout        = r_timeout;
    assign err_count      = r_err_count;
    assign first_err_addr = r_first_err_addr;
    assign aw_valid       = r_aw_valid;
    assign aw_addr        = r_aw_addr;
    assign aw_prot        = 1'b0;
    assign w_valid        = r_w_valid;
    assign w_data         = r_w_data;
    assign w_strb         = '1;
    assign b_ready        = r_b_ready;
    assign ar_valid       = r_ar_valid;
    assign ar_addr        = r_ar_addr;
    assign ar_prot        = 1'b0;
    assign r_ready        = r_r_ready;

endmodule

// File: tb/tb_axi_sram_tester.sv
// Directed bench for axi_sram_tester: negedge-driven SRAM slave model with
// stall / error / silent-B knobs, and one task per scenario.
module tb_axi_sram_tester;
    import axi_sram_tester_pkg::*;

    localparam int AW = 18;
    localparam int DW = 16;

    logic          a_clk = 1'b0, a_rst = 1'b0, start = 1'b0;
    logic [AW-1:0] base = '0, len = '0;
    logic [DW-1:0] seed = '0;
    logic          busy, done, pass, timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr, aw_addr, ar_addr;
    logic          aw_valid, aw_prot, w_valid, b_ready, ar_valid, ar_prot, r_ready;
    logic [DW-1:0] w_data;
    logic [1:0]    w_strb;
    logic          aw_ready = 0, w_ready = 0, b_valid = 0, ar_ready = 0, r_valid = 0;
    logic [1:0]    b_resp = 0, r_resp = 0;
    logic [DW-1:0] r_data = 0;

    int n_checks = 0, n_errors = 0;

    // slave knobs (written by the test sequence only)
    int aw_stall = 0, w_stall = 0, flip_addr = -1;
    bit b_never = 0;

    // slave state (written by the slave process only)
    logic [DW-1:0] mem [int];
    int  wa_q[$], wd_q[$], ra_q[$];
    int  aw_log[$], w_log[$], ar_log[$];
    int  aw_cnt = 0, w_cnt = 0;
    bit  aw_fire = 0, w_fire = 0, b_fire = 0, ar_fire = 0, r_fire = 0;

    always #5 a_clk = ~a_clk;

    axi_sram_tester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
        .a_clk(a_clk), .a_rst(a_rst), .start(start), .base(base), .len(len), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
        .first_err_addr(first_err_addr),
        .aw_valid(aw_valid), .aw_addr(aw_addr), .aw_prot(aw_prot), .aw_ready(aw_ready),
        .w_valid(w_valid), .w_data(w_data), .w_strb(w_strb), .w_ready(w_ready),
        .b_ready(b_ready), .b_valid(b_valid), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_prot(ar_prot), .ar_ready(ar_ready),
        .r_ready(r_ready), .r_valid(r_valid), .r_data(r_data), .r_resp(r_resp)
    );

    // Responses are issued on the negedge; a *_fire flag marks a handshake that
    // completes on the following posedge. B/R are processed before AW/W/AR so a
    // response never precedes its address handshake.
    always @(negedge a_clk) begin
        if (!a_rst) begin
            aw_ready = 0; w_ready = 0; b_valid = 0; ar_ready = 0; r_valid = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            aw_cnt = 0; w_cnt = 0;
            wa_q.delete(); wd_q.delete(); ra_q.delete();
        end else begin
            if (b_fire) begin b_valid = 0; b_fire = 0; end
            else if (!b_valid && !b_never && wa_q.size() > 0 && wd_q.size() > 0) begin
                mem[wa_q.pop_front()] = DW'(wd_q.pop_front());
                b_valid = 1; b_resp = RESP_OKAY;
            end
            if (b_valid && b_ready) b_fire = 1;

            if (r_fire) begin r_valid = 0; r_fire = 0; end
            else if (!r_valid && ra_q.size() > 0) begin
                int a;
                a = ra_q.pop_front();
                r_data = mem.exists(a) ? mem[a] : '0;
                if (a == flip_addr) r_data[0] = ~r_data[0];
                r_valid = 1; r_resp = RESP_OKAY;
            end
            if (r_valid && r_ready) r_fire = 1;

            if (aw_fire) begin aw_ready = 0; aw_fire = 0; aw_cnt = 0; end
            else if (aw_valid) begin
                if (aw_cnt >= aw_stall) begin
                    aw_ready = 1; aw_fire = 1;
                    wa_q.push_back(int'(aw_addr)); aw_log.push_back(int'(aw_addr));
                end else aw_cnt++;
            end

            if (w_fire) begin w_ready = 0; w_fire = 0; w_cnt = 0; end
            else if (w_valid) begin
                if (w_cnt >= w_stall) begin
                    w_ready = 1; w_fire = 1;
                    wd_q.push_back(int'(w_data)); w_log.push_back(int'(w_data));
                end else w_cnt++;
            end

            if (ar_fire) begin ar_ready = 0; ar_fire = 0; end
            else if (ar_valid) begin
                ar_ready = 1; ar_fire = 1;
                ra_q.push_back(int'(ar_addr)); ar_log.push_back(int'(ar_addr));
            end
        end
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic [DW-1:0] s);
        @(posedge a_clk); #1;
        base = b; len = l; seed = s; start = 1'b1;
        @(posedge a_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output int cyc);
        cyc = -1;
        for (int k = 1; k <= maxc; k++) begin
            @(posedge a_clk); #1;
            if (done === 1'b1) begin cyc = k; break; end
        end
    endtask

    task automatic test_reset();
        a_rst = 1'b0;
        repeat (3) @(posedge a_clk);
        #1;
        n_checks++;
        if ({busy, done, pass, timeout, aw_valid, w_valid, b_ready, ar_valid, r_ready} !== 9'b0) begin
            n_errors++; $display("FAIL reset_ctrl: got %b expected 0",
                {busy, done, pass, timeout, aw_valid, w_valid, b_ready, ar_valid, r_ready});
        end
        n_checks++;
        if (err_count !== 16'h0 || first_err_addr !== '0) begin
            n_errors++; $display("FAIL reset_results: err_count=%0h first=%0h expected 0", err_count, first_err_addr);
        end
        n_checks++;
        if (aw_addr !== '0 || ar_addr !== '0 || aw_prot !== 1'b0 || ar_prot !== 1'b0 || w_strb !== 2'b11) begin
            n_errors++; $display("FAIL reset_addr: aw=%0h ar=%0h prot=%b%b strb=%b", aw_addr, ar_addr, aw_prot, ar_prot, w_strb);
        end
        a_rst = 1'b1;
    endtask

    task automatic test_basic();
        int cyc, n0, r0;
        logic [AW-1:0] exp_a [4];
        logic [DW-1:0] exp_d [4];
        exp_a[0] = 18'h0; exp_a[1] = 18'h1; exp_a[2] = 18'h2; exp_a[3] = 18'h3;
        exp_d[0] = 16'hA5A5; exp_d[1] = 16'hA5A4; exp_d[2] = 16'hA5A7; exp_d[3] = 16'hA5A6;
        n0 = aw_log.size(); r0 = ar_log.size();
        do_start(18'h0, 18'd4, 16'hA5A5);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_done(40, cyc);
        n_checks++;
        if (cyc !== 17) begin n_errors++; $display("FAIL basic_latency: done at %0d expected 17", cyc); end
        n_checks++;
        if ({busy, pass, timeout} !== 3'b010 || err_count !== 16'h0) begin
            n_errors++; $display("FAIL basic_result: busy/pass/to=%b err=%0h expected 010/0", {busy, pass, timeout}, err_count);
        end
        // start held during the done cycle must be ignored
        base = 18'h100; len = 18'd1; start = 1'b1;
        @(posedge a_clk); #1;
        start = 1'b0;
        n_checks++;
        if ({busy, done, aw_valid} !== 3'b000) begin
            n_errors++; $display("FAIL start_during_done: busy/done/awv=%b expected 000", {busy, done, aw_valid});
        end
        repeat (3) @(posedge a_clk);
        #1;
        n_checks++;
        if (aw_log.size() - n0 !== 4 || ar_log.size() - r0 !== 4 || w_log.size() - n0 !== 4) begin
            n_errors++; $display("FAIL basic_txn_count: aw=%0d w=%0d ar=%0d expected 4", aw_log.size() - n0, w_log.size() - n0, ar_log.size() - r0);
        end
        n_checks++;
        if (pass !== 1'b1) begin n_errors++; $display("FAIL basic_pass_hold: got %b expected 1", pass); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (aw_log[n0+i] !== int'(exp_a[i]) || w_log[n0+i] !== int'(exp_d[i]) || ar_log[r0+i] !== int'(exp_a[i])) begin
                n_errors++; $display("FAIL basic_word%0d: aw=%0h w=%0h ar=%0h expected %0h/%0h", i,
                    aw_log[n0+i], w_log[n0+i], ar_log[r0+i], exp_a[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_wrap();
        int cyc, n0, r0;
        logic [AW-1:0] exp_a [4];
        exp_a[0] = 18'h3FFFE; exp_a[1] = 18'h3FFFF; exp_a[2] = 18'h0; exp_a[3] = 18'h1;
        n0 = aw_log.size(); r0 = ar_log.size();
        do_start(18'h3FFFE, 18'd4, 16'h0);
        wait_done(60, cyc);
        n_checks++;
        if (cyc < 0) begin n_errors++; $display("FAIL wrap_done: no done within 60 cycles"); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (aw_log[n0+i] !== int'(exp_a[i]) || ar_log[r0+i] !== int'(exp_a[i])) begin
                n_errors++; $display("FAIL wrap_addr%0d: aw=%0h ar=%0h expected %0h", i, aw_log[n0+i], ar_log[r0+i], exp_a[i]);
            end
        end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 16'h0) begin
            n_errors++; $display("FAIL wrap_pass: pass=%b err=%0h expected 1/0", pass, err_count);
        end
    endtask

    task automatic test_mismatch();
        int cyc;
        flip_addr = 32'h10;
        do_start(18'h0E, 18'd4, 16'h1234);
        n_checks++;
        if (pass !== 1'b0 || err_count !== 16'h0) begin
            n_errors++; $display("FAIL mismatch_clear: pass=%b err=%0h expected 0/0", pass, err_count);
        end
        wait_done(60, cyc);
        flip_addr = -1;
        n_checks++;
        if (cyc < 0) begin n_errors++; $display("FAIL mismatch_done: no done within 60 cycles"); end
        n_checks++;
        if (err_count !== 16'd1 || first_err_addr !== 18'h10 || pass !== 1'b0 || timeout !== 1'b0) begin
            n_errors++; $display("FAIL mismatch_result: err=%0h first=%0h pass=%b to=%b expected 1/10/0/0",
                err_count, first_err_addr, pass, timeout);
        end
    endtask

    task automatic test_stall();
        int cyc, n0;
        logic [7:0] ev_aw, ev_w, ev_br, ev_ar;
        ev_aw = 8'b00111111; ev_w = 8'b00000111; ev_br = 8'b01000000; ev_ar = 8'b10000000;
        aw_stall = 5; w_stall = 2;
        n0 = aw_log.size();
        do_start(18'h20, 18'd1, 16'h0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(posedge a_clk); #1; end
            n_checks++;
            if ({aw_valid, w_valid, b_ready, ar_valid} !== {ev_aw[k], ev_w[k], ev_br[k], ev_ar[k]}) begin
                n_errors++; $display("FAIL stall_t%0d: aw/w/b/ar=%b expected %b", k,
                    {aw_valid, w_valid, b_ready, ar_valid}, {ev_aw[k], ev_w[k], ev_br[k], ev_ar[k]});
            end
            n_checks++;
            if ((aw_valid && aw_addr !== 18'h20) || (w_valid && w_data !== 16'h0020)) begin
                n_errors++; $display("FAIL stall_payload_t%0d: addr=%0h data=%0h expected 20/0020", k, aw_addr, w_data);
            end
        end
        aw_stall = 0; w_stall = 0;
        wait_done(30, cyc);
        n_checks++;
        if (cyc < 0 || pass !== 1'b1) begin n_errors++; $display("FAIL stall_done: cyc=%0d pass=%b expected done/1", cyc, pass); end
        n_checks++;
        if (aw_log.size() - n0 !== 1 || w_log.size() - n0 !== 1) begin
            n_errors++; $display("FAIL stall_dup: aw=%0d w=%0d expected 1", aw_log.size() - n0, w_log.size() - n0);
        end
    endtask

    task automatic test_timeout();
        logic [10:0] ev_br, ev_to, ev_dn;
        ev_br = 11'b00111111110; ev_to = 11'b11000000000; ev_dn = 11'b10000000000;
        b_never = 1'b1;
        do_start(18'h30, 18'd1, 16'h0);
        for (int k = 0; k < 11; k++) begin
            if (k > 0) begin @(posedge a_clk); #1; end
            n_checks++;
            if ({b_ready, timeout, done} !== {ev_br[k], ev_to[k], ev_dn[k]}) begin
                n_errors++; $display("FAIL timeout_t%0d: bready/to/done=%b expected %b", k,
                    {b_ready, timeout, done}, {ev_br[k], ev_to[k], ev_dn[k]});
            end
        end
        n_checks++;
        if (pass !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL timeout_pass: pass=%b busy=%b expected 0/0", pass, busy); end
        b_never = 1'b0;
        // flush the slave's unanswered write
        @(posedge a_clk); #1 a_rst = 1'b0;
        repeat (2) @(posedge a_clk);
        #1 a_rst = 1'b1;
    endtask

    task automatic test_reset_mid_and_len0();
        int n0, r0;
        bit seen;
        seen = 0;
        do_start(18'h40, 18'd4, 16'h0);
        for (int k = 0; k < 40; k++) begin
            if (ar_valid === 1'b1) begin seen = 1; break; end
            @(posedge a_clk); #1;
        end
        n_checks++;
        if (!seen) begin n_errors++; $display("FAIL midreset_reach: ar_valid never seen expected 1"); end
        a_rst = 1'b0;
        @(posedge a_clk); #1;
        n_checks++;
        if ({ar_valid, r_ready, aw_valid, w_valid, b_ready, busy, done} !== 7'b0) begin
            n_errors++; $display("FAIL midreset_drop: got %b expected 0",
                {ar_valid, r_ready, aw_valid, w_valid, b_ready, busy, done});
        end
        @(posedge a_clk); #1 a_rst = 1'b1;
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL midreset_nodone: done=%b expected 0", done); end
        n0 = aw_log.size(); r0 = ar_log.size();
        do_start(18'h50, 18'd0, 16'h0);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL len0_t0: done=%b busy=%b expected 0/0", done, busy); end
        @(posedge a_clk); #1;
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin n_errors++; $display("FAIL len0_t1: done=%b pass=%b expected 1/1", done, pass); end
        @(posedge a_clk); #1;
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL len0_t2: done=%b expected 0", done); end
        n_checks++;
        if (aw_log.size() != n0 || ar_log.size() != r0 || aw_valid !== 1'b0 || ar_valid !== 1'b0) begin
            n_errors++; $display("FAIL len0_traffic: aw=%0d ar=%0d expected 0", aw_log.size() - n0, ar_log.size() - r0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_mismatch();
        test_stall();
        test_timeout();
        test_reset_mid_and_len0();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
